block_ram_arbiter: RTL and testbench
====================================

BLOCK_RAM_ARBITER -- requirements
Module: block_ram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter BYTE_WIDTH, default 1: RAM word width in bytes.
REQ-003 SHALL have parameter ADDR_WIDTH, default 1: RAM address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req, input, NUM_REQ bits: per-requester request, held high until acked.
REQ-007 SHALL have port req_we, input, NUM_REQ bits: 1 = write, 0 = read.
REQ-008 SHALL have port req_ben, input, NUM_REQ*BYTE_WIDTH bits: packed per-requester byte enables.
REQ-009 SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH bits: packed per-requester addresses.
REQ-010 SHALL have port req_wdata, input, NUM_REQ*BYTE_WIDTH*8 bits: packed per-requester write data.
REQ-011 SHALL have port ack, output, NUM_REQ bits: one-cycle command-accepted pulse.
REQ-012 SHALL have port rvalid, output, NUM_REQ bits: one-cycle read-data-valid pulse.
REQ-013 SHALL have port rdata, output, BYTE_WIDTH*8 bits: read data shared by all requesters, qualified by rvalid.
REQ-014 SHALL have ports ram_wr_en (1), ram_wr_ben (BYTE_WIDTH), ram_wr_addr (ADDR_WIDTH), ram_wr_data (BYTE_WIDTH*8), all outputs: drive the RAM write port.
REQ-015 SHALL have ports ram_rd_en (1 bit, output), ram_rd_addr (ADDR_WIDTH, output) and ram_rd_data (BYTE_WIDTH*8, input): drive and return the RAM read port.
REQ-016 SHALL be connected with the RAM's read and write clocks tied to clk and both RAM resets tied to rstn.

Function
REQ-017 SHALL accept at most one command per cycle.
REQ-018 SHALL select the winner round-robin: the highest priority is the requester after the last winner, wrapping from NUM_REQ-1 to 0.
REQ-019 SHALL mask a requester from arbitration in any cycle where its ack is high.
- Its held req is therefore not double-accepted.
REQ-020 SHALL register the winning command at the edge ending cycle N; in cycle N+1, ack[winner] is high and exactly one of ram_wr_en or ram_rd_en is high, carrying that command's fields.
REQ-021 SHALL de-assert ram_wr_en and ram_rd_en in any cycle after an edge that had no eligible request.
- The registered address, data and ben fields hold their last values.
REQ-022 SHALL route a read accepted in cycle N as follows: ram_rd_en in cycle N+1, RAM data in N+2, rvalid[winner] high in N+2 with rdata = ram_rd_data.
REQ-023 SHALL track read ownership in a registered one-hot tag pipeline of depth 2; rvalid SHALL never have more than one bit set.
REQ-024 SHALL update the round-robin pointer only on an accepted command; the pointer SHALL be unchanged in idle cycles.
REQ-025 SHALL sustain one command per cycle when two or more requesters alternate; a single requester alone SHALL get one command per two cycles.
REQ-026 SHALL make a read issued in the cycle after a write to the same address return the newly written data.
REQ-027 SHALL leave the RAM write port unaffected when a write command has ben = 0, other than issuing ram_wr_en.
- ack SHALL still pulse.
REQ-028 SHALL be insensitive to the requester's req_we/ben/addr/wdata except in the accepting cycle.

Reset
REQ-029 SHALL, while rstn is low, force ack, rvalid, ram_wr_en, ram_rd_en, the tag pipeline and all registered fields to 0, and set the pointer so requester 0 has highest priority.
REQ-030 SHALL discard any read in flight when rstn asserts mid-operation; no rvalid SHALL follow reset release for it.
REQ-031 SHALL permit the first acceptance in the cycle after rstn de-asserts.

Structure
REQ-032 SHALL use no shared package; all widths SHALL derive from module parameters via local constants.
REQ-033 SHALL place the round-robin winner selection (req vector and pointer in, one-hot grant out, purely combinational) in sub-module rr_priority_select.

Verification
REQ-034 SHALL cover: req=01, req_we=1, addr=5, wdata=0xA5, ben=1 -> ack[0] and ram_wr_en in the next cycle, ram_wr_addr=5, ram_wr_data=0xA5.
REQ-035 SHALL cover: the req=01 write above, then a read of addr 5 by requester 1 -> rvalid[1] two cycles after its acceptance, rdata=0xA5.
REQ-036 SHALL cover: req=11 held continuously after reset -> grants alternate 0,1,0,1 and ack is high every cycle.
REQ-037 SHALL cover: NUM_REQ=4, req=1111 -> grant order 0,1,2,3,0; then req=1000 only -> requester 3 granted every other cycle.
REQ-038 SHALL cover: rstn pulsed low the cycle after a read is accepted -> no rvalid afterward, all outputs 0, next grant goes to requester 0.
REQ-039 SHALL cover: a write with ben=0 to addr 2 holding 0x3C, then a read of addr 2 -> rdata=0x3C.

Source files
------------

// File: rtl/block_ram_arbiter_if.sv
// Requester-side bundle of the block RAM arbiter: per-requester commands in,
// per-requester acknowledge/read-valid and the shared read data out.
interface block_ram_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int BYTE_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
);
  localparam int DATA_W = BYTE_WIDTH * 8;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*BYTE_WIDTH-1:0] req_ben;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0]     req_wdata;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_W-1:0]             rdata;

  modport master (
    output req, req_we, req_ben, req_addr, req_wdata,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  req, req_we, req_ben, req_addr, req_wdata,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/block_ram_arbiter_rr_priority_select.sv
// Combinational round-robin pick: the first set request at or above the pointer,
// otherwise the lowest set request overall. Grant is one-hot or zero.
module rr_priority_select #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_hi_req;
  logic [NUM_REQ-1:0] w_hi_grant;
  logic [NUM_REQ-1:0] w_lo_grant;

  // Requests at or above the pointer form the higher-priority window
  always_comb begin
    w_mask = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (PTR_W'(i) >= i_ptr);
    end
  end

  // Isolate the lowest set bit of each window; the upper window wins when non-empty
  always_comb begin
    w_hi_req   = i_req & w_mask;
    w_hi_grant = w_hi_req & (~w_hi_req + ONE);
    w_lo_grant = i_req & (~i_req + ONE);
    if (|w_hi_req) begin
      o_grant = w_hi_grant;
    end else begin
      o_grant = w_lo_grant;
    end
  end
endmodule

// File: rtl/block_ram_arbiter.sv
// Round-robin arbiter sharing one simple dual-port RAM among NUM_REQ requesters.
// Accepted commands drive the RAM one cycle later; read data returns one cycle after that.
module block_ram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int BYTE_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*BYTE_WIDTH-1:0]   req_ben,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*BYTE_WIDTH*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]              ack,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [BYTE_WIDTH*8-1:0]         rdata,
  output logic                            ram_wr_en,
  output logic [BYTE_WIDTH-1:0]           ram_wr_ben,
  output logic [ADDR_WIDTH-1:0]           ram_wr_addr,
  output logic [BYTE_WIDTH*8-1:0]         ram_wr_data,
  output logic                            ram_rd_en,
  output logic [ADDR_WIDTH-1:0]           ram_rd_addr,
  input  logic [BYTE_WIDTH*8-1:0]         ram_rd_data
);
  localparam int DATA_W = BYTE_WIDTH * 8;
  localparam int PTR_W  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_any;
  logic [PTR_W-1:0]      w_win_idx;
  logic [PTR_W-1:0]      w_next_ptr;
  logic                  w_win_we;
  logic [BYTE_WIDTH-1:0] w_win_ben;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_W-1:0]     w_win_wdata;

  logic [PTR_W-1:0]      r_ptr;
  logic [NUM_REQ-1:0]    r_ack;
  logic [NUM_REQ-1:0]    r_tag_rd;
  logic [NUM_REQ-1:0]    r_tag_rv;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic [BYTE_WIDTH-1:0] r_wr_ben;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_W-1:0]     r_wr_data;
  logic [ADDR_WIDTH-1:0] r_rd_addr;

  // A requester being acked this cycle is still holding its old req, so hide it
  assign w_elig = req & ~r_ack;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_priority_select (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // One-hot grant selects the winner's index and command fields (AND-OR mux)
  always_comb begin
    w_any       = |w_grant;
    w_win_idx   = {PTR_W{1'b0}};
    w_win_we    = 1'b0;
    w_win_ben   = {BYTE_WIDTH{1'b0}};
    w_win_addr  = {ADDR_WIDTH{1'b0}};
    w_win_wdata = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_win_idx   = w_win_idx   | (w_grant[i] ? PTR_W'(i) : {PTR_W{1'b0}});
      w_win_we    = w_win_we    | (w_grant[i] & req_we[i]);
      w_win_ben   = w_win_ben   | ({BYTE_WIDTH{w_grant[i]}} & req_ben[i*BYTE_WIDTH +: BYTE_WIDTH]);
      w_win_addr  = w_win_addr  | ({ADDR_WIDTH{w_grant[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      w_win_wdata = w_win_wdata | ({DATA_W{w_grant[i]}} & req_wdata[i*DATA_W +: DATA_W]);
    end
  end

  // Priority moves to the requester after the winner, wrapping at NUM_REQ-1
  always_comb begin
    if (w_win_idx == PTR_W'(NUM_REQ - 1)) begin
      w_next_ptr = {PTR_W{1'b0}};
    end else begin
      w_next_ptr = w_win_idx + PTR_W'(1);
    end
  end

  // Control path: ack, RAM enables, read-ownership tags and the round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr    <= {PTR_W{1'b0}};
      r_ack    <= {NUM_REQ{1'b0}};
      r_tag_rd <= {NUM_REQ{1'b0}};
      r_tag_rv <= {NUM_REQ{1'b0}};
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
    end else begin
      r_ack    <= w_grant;
      r_wr_en  <= w_any & w_win_we;
      r_rd_en  <= w_any & ~w_win_we;
      r_tag_rd <= w_win_we ? {NUM_REQ{1'b0}} : w_grant;
      r_tag_rv <= r_tag_rd;
      if (w_any) begin
        r_ptr <= w_next_ptr;
      end
    end
  end

  // Data path: command fields are captured only on acceptance and otherwise hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ben  <= {BYTE_WIDTH{1'b0}};
      r_wr_addr <= {ADDR_WIDTH{1'b0}};
      r_wr_data <= {DATA_W{1'b0}};
      r_rd_addr <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (w_any && w_win_we) begin
        r_wr_ben  <= w_win_ben;
        r_wr_addr <= w_win_addr;
        r_wr_data <= w_win_wdata;
      end
      if (w_any && !w_win_we) begin
        r_rd_addr <= w_win_addr;
      end
    end
  end

  assign ack         = r_ack;
  assign rvalid      = r_tag_rv;
  assign rdata       = ram_rd_data;
  assign ram_wr_en   = r_wr_en;
  assign ram_wr_ben  = r_wr_ben;
  assign ram_wr_addr = r_wr_addr;
  assign ram_wr_data = r_wr_data;
  assign ram_rd_en   = r_rd_en;
  assign ram_rd_addr = r_rd_addr;
endmodule

// File: tb/tb_block_ram_arbiter.sv
// Scoreboard bench for block_ram_arbiter with four requesters and a behavioural RAM.
// A queue-based reference model predicts each accept and read return; a monitor checks them.
module tb_block_ram_arbiter;
  localparam int NR = 4;
  localparam int BW = 1;
  localparam int AW = 4;
  localparam int DW = BW * 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  block_ram_arbiter_if #(.NUM_REQ(NR), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  logic          ram_wr_en, ram_rd_en;
  logic [BW-1:0] ram_wr_ben;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  block_ram_arbiter #(.NUM_REQ(NR), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (bus.req),
    .req_we      (bus.req_we),
    .req_ben     (bus.req_ben),
    .req_addr    (bus.req_addr),
    .req_wdata   (bus.req_wdata),
    .ack         (bus.ack),
    .rvalid      (bus.rvalid),
    .rdata       (bus.rdata),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_ben  (ram_wr_ben),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // Simple dual-port RAM with registered read, clocks on clk and reset on rstn
  logic [DW-1:0] ram_mem [16] = '{default: 8'h00};
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_rd_data <= '0;
    end else begin
      if (ram_wr_en)
        for (int b = 0; b < BW; b++)
          if (ram_wr_ben[b]) ram_mem[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
      if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
    end
  end

  typedef struct {
    int cyc; int idx; bit we;
    logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] ben;
  } cmd_t;
  typedef struct { int cyc; int idx; logic [DW-1:0] data; } rd_t;
  typedef struct { int cyc; int idx; } log_t;

  cmd_t exp_cmd[$];
  rd_t  exp_rd[$];
  log_t grant_log[$];
  rd_t  rd_log[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: pending command per requester, priority index, memory image
  logic [NR-1:0] pend    = '0;
  logic [NR-1:0] ack_now = '0;
  bit            p_we    [NR];
  logic [AW-1:0] p_addr  [NR];
  logic [DW-1:0] p_wdata [NR];
  logic [BW-1:0] p_ben   [NR];
  int            ptr = 0;
  logic [DW-1:0] model_mem [16] = '{default: 8'h00};

  function automatic int pick(input logic [NR-1:0] elig, input int p);
    for (int k = 0; k < NR; k++)
      if (elig[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic issue(input int i, input bit we, input int addr, input int wdata, input int ben);
    if (!pend[i]) begin
      pend[i]    = 1'b1;
      p_we[i]    = we;
      p_addr[i]  = AW'(addr);
      p_wdata[i] = DW'(wdata);
      p_ben[i]   = BW'(ben);
    end
  endtask

  // Idle requesters present junk fields, which must be ignored
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req[i] = pend[i];
      if (pend[i]) begin
        bus.req_we[i] = p_we[i];
        bus.req_ben[i*BW +: BW] = p_ben[i];
        bus.req_addr[i*AW +: AW] = p_addr[i];
        bus.req_wdata[i*DW +: DW] = p_wdata[i];
      end else begin
        bus.req_we[i] = 1'($urandom);
        bus.req_ben[i*BW +: BW] = BW'($urandom);
        bus.req_addr[i*AW +: AW] = AW'($urandom);
        bus.req_wdata[i*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic tick();
    int w;
    cmd_t c;
    rd_t r;
    logic [NR-1:0] nxt;
    drive();
    nxt = '0;
    w = pick(pend & ~ack_now, ptr);
    if (w >= 0) begin
      c.cyc = cyc + 1; c.idx = w; c.we = p_we[w];
      c.addr = p_addr[w]; c.wdata = p_wdata[w]; c.ben = p_ben[w];
      exp_cmd.push_back(c);
      if (p_we[w]) begin
        for (int b = 0; b < BW; b++)
          if (p_ben[w][b]) model_mem[p_addr[w]][b*8 +: 8] = p_wdata[w][b*8 +: 8];
      end else begin
        r.cyc = cyc + 2; r.idx = w; r.data = model_mem[p_addr[w]];
        exp_rd.push_back(r);
      end
      ptr = (w + 1) % NR;
      nxt[w] = 1'b1;
    end
    @(posedge clk); #1;
    ack_now = nxt;
    pend = pend & ~ack_now;
  endtask

  task automatic drain();
    int n = 0;
    while (pend != '0 && n < 40) begin tick(); n++; end
    chk("drain_bound", 64'(pend), 64'(0));
    tick(); tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    exp_cmd.delete(); exp_rd.delete();
    pend = '0; ack_now = '0; ptr = 0;
    drive();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Monitor: pop expectations whenever the DUT presents ack or rvalid
  always @(negedge clk) begin
    cmd_t c;
    rd_t r;
    log_t g;
    rd_t o;
    logic [NR-1:0] e;
    if (!rstn) begin
      chk("rst_ack", 64'(bus.ack), 64'(0));
      chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
      chk("rst_wr_en", 64'(ram_wr_en), 64'(0));
      chk("rst_rd_en", 64'(ram_rd_en), 64'(0));
      chk("rst_wr_fields", 64'({ram_wr_ben, ram_wr_addr, ram_wr_data}), 64'(0));
      chk("rst_rd_addr", 64'(ram_rd_addr), 64'(0));
    end else begin
      if (bus.ack != '0) begin
        g.cyc = cyc; g.idx = onehot_idx(bus.ack);
        grant_log.push_back(g);
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ack=%b expected none", bus.ack);
        end else begin
          c = exp_cmd.pop_front();
          e = '0; e[c.idx] = 1'b1;
          chk("ack_cycle", 64'(cyc), 64'(c.cyc));
          chk("ack_vec", 64'(bus.ack), 64'(e));
          chk("wr_en", 64'(ram_wr_en), 64'(c.we));
          chk("rd_en", 64'(ram_rd_en), 64'(!c.we));
          if (c.we) begin
            chk("wr_addr", 64'(ram_wr_addr), 64'(c.addr));
            chk("wr_data", 64'(ram_wr_data), 64'(c.wdata));
            chk("wr_ben", 64'(ram_wr_ben), 64'(c.ben));
          end else begin
            chk("rd_addr", 64'(ram_rd_addr), 64'(c.addr));
          end
        end
      end else begin
        chk("idle_enables", 64'({ram_wr_en, ram_rd_en}), 64'(0));
      end
      if (bus.rvalid != '0) begin
        o.cyc = cyc; o.idx = onehot_idx(bus.rvalid); o.data = bus.rdata;
        rd_log.push_back(o);
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rvalid: got rvalid=%b expected none", bus.rvalid);
        end else begin
          r = exp_rd.pop_front();
          e = '0; e[r.idx] = 1'b1;
          chk("rvalid_cycle", 64'(cyc), 64'(r.cyc));
          chk("rvalid_vec", 64'(bus.rvalid), 64'(e));
          chk("rdata", 64'(bus.rdata), 64'(r.data));
        end
      end
    end
  end

  initial begin
    int rel;
    int acc;
    bus.req = '0; bus.req_we = '0; bus.req_ben = '0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Two requesters held high: strict alternation with an ack every cycle
    grant_log.delete();
    for (int n = 0; n < 8; n++) begin
      issue(0, 1'b1, n, 8'h10 + n, 1);
      issue(1, 1'b1, n + 8, 8'h20 + n, 1);
      tick();
    end
    drain();
    if (grant_log.size() < 8) begin
      checks++; errors++;
      $display("FAIL alt_grant_count: got %0d expected 8", grant_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        chk("alt_grant", 64'(grant_log[k].idx), 64'(k % 2));
        chk("alt_every_cycle", 64'(grant_log[k].cyc), 64'(grant_log[0].cyc + k));
      end
    end

    // Four requesters: rotation 0,1,2,3,0; then requester 3 alone every other cycle
    do_reset();
    rel = cyc;
    grant_log.delete();
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < NR; i++) issue(i, 1'b0, i, 0, 0);
      tick();
    end
    drain();
    if (grant_log.size() < 5) begin
      checks++; errors++;
      $display("FAIL rot_grant_count: got %0d expected 5", grant_log.size());
    end else begin
      chk("first_after_reset", 64'(grant_log[0].cyc), 64'(rel + 1));
      for (int k = 0; k < 5; k++) chk("rot_grant", 64'(grant_log[k].idx), 64'(k % 4));
    end
    grant_log.delete();
    for (int n = 0; n < 8; n++) begin
      issue(3, 1'b1, 3, n, 1);
      tick();
    end
    drain();
    if (grant_log.size() < 4) begin
      checks++; errors++;
      $display("FAIL solo_grant_count: got %0d expected 4", grant_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk("solo_grant", 64'(grant_log[k].idx), 64'(3));
        chk("solo_spacing", 64'(grant_log[k].cyc), 64'(grant_log[0].cyc + 2 * k));
      end
    end

    // Write A5 to address 5, then read it back through requester 1
    issue(0, 1'b1, 5, 8'hA5, 1);
    tick();
    chk("w5_ack", 64'(bus.ack), 64'(4'b0001));
    chk("w5_wr_en", 64'(ram_wr_en), 64'(1));
    chk("w5_addr", 64'(ram_wr_addr), 64'(5));
    chk("w5_data", 64'(ram_wr_data), 64'(8'hA5));
    rd_log.delete();
    acc = cyc;
    issue(1, 1'b0, 5, 0, 0);
    tick();
    drain();
    if (rd_log.size() != 1) begin
      checks++; errors++;
      $display("FAIL r5_count: got %0d expected 1", rd_log.size());
    end else begin
      chk("r5_idx", 64'(rd_log[0].idx), 64'(1));
      chk("r5_cycle", 64'(rd_log[0].cyc), 64'(acc + 2));
      chk("r5_data", 64'(rd_log[0].data), 64'(8'hA5));
    end

    // Zero-byte-enable write leaves the stored value intact
    rd_log.delete();
    issue(0, 1'b1, 2, 8'h3C, 1); tick();
    issue(1, 1'b1, 2, 8'hFF, 0); tick();
    issue(0, 1'b0, 2, 0, 0);     tick();
    drain();
    if (rd_log.size() != 1) begin
      checks++; errors++;
      $display("FAIL ben0_count: got %0d expected 1", rd_log.size());
    end else begin
      chk("ben0_data", 64'(rd_log[0].data), 64'(8'h3C));
    end

    // Reset the cycle after a read is accepted: no rvalid, priority back to 0
    rd_log.delete();
    issue(1, 1'b0, 5, 0, 0);
    tick();
    @(negedge clk);
    #2;
    do_reset();
    tick(); tick(); tick();
    chk("rst_no_rvalid", 64'(rd_log.size()), 64'(0));
    issue(3, 1'b0, 1, 0, 0);
    issue(0, 1'b0, 2, 0, 0);
    tick();
    chk("rst_next_grant", 64'(bus.ack), 64'(4'b0001));
    drain();

    // Randomised traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1)
          issue(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      tick();
    end
    drain();
    chk("exp_cmd_empty", 64'(exp_cmd.size()), 64'(0));
    chk("exp_rd_empty", 64'(exp_rd.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
